// File: rtl/visu_mon_grid.sv
// Debug indicator grid monitor: holds NUM_LEDS (colour, mode) entries written through a
// falling-edge chip-select strobe and renders them as a grid of bordered tiles on a VGA
// raster. Entries can be off, on, or blink in either phase. Colours come from the C64
// palette. Also produces a summary LED and flags writes to an index that does not exist.
module visu_mon_grid #(
  parameter int unsigned NUM_LEDS     = 16,
  parameter int unsigned LED_W        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  parameter int unsigned COLS         = 8,
  parameter int unsigned TILE_PX      = 32,
  parameter int unsigned BORDER_PX    = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned H_VIS        = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_VIS        = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33
) (
  input  logic             i_clkVideo,
  input  logic             i_reset,
  input  logic             i_cs,
  input  logic [LED_W-1:0] i_ledNo,
  input  logic [3:0]       i_color,
  input  logic [1:0]       i_mode,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [3:0]       o_red,
  output logic [3:0]       o_green,
  output logic [3:0]       o_blue,
  output logic             o_led,
  output logic             o_wrErr
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned TSH     = $clog2(TILE_PX);

  // C64 16-colour palette, 4 bits per channel
  function automatic logic [11:0] palette(input logic [3:0] c);
    logic [11:0] rgb;
    rgb = 12'h000;
    case (c)
      4'd0:  rgb = 12'h000;  // black
      4'd1:  rgb = 12'hFFF;  // white
      4'd2:  rgb = 12'h800;  // red
      4'd3:  rgb = 12'hAFE;  // cyan
      4'd4:  rgb = 12'hC4C;  // magenta
      4'd5:  rgb = 12'h0C5;  // green
      4'd6:  rgb = 12'h00A;  // blue
      4'd7:  rgb = 12'hEE7;  // yellow
      4'd8:  rgb = 12'hD85;  // orange
      4'd9:  rgb = 12'h640;  // brown
      4'd10: rgb = 12'hF77;  // light red
      4'd11: rgb = 12'h333;  // dark grey
      4'd12: rgb = 12'h777;  // grey
      4'd13: rgb = 12'hAF6;  // light green
      4'd14: rgb = 12'h08F;  // light blue
      4'd15: rgb = 12'hBBB;  // light grey
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;
  logic [7:0]    fcnt_q;
  logic          phase_q;
  logic          cs_q;
  logic          wr, wr_in;
  logic          led_any;
  logic [3:0]    color_q [NUM_LEDS];
  logic [1:0]    mode_q  [NUM_LEDS];

  assign wr    = cs_q & ~i_cs;
  assign wr_in = 32'(i_ledNo) < NUM_LEDS;

  // Raster counters: hcnt wraps at line end and advances vcnt
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_q <= '0;
      vcnt_q <= (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_q <= hcnt_q + 1'b1;
    end
  end

  // Blink timebase: counts frame starts, toggles phase every BLINK_FRAMES frames
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (hcnt_q == '0 && vcnt_q == '0) begin
      if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
        fcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // Strobe edge detect, error pulse and summary LED
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      cs_q    <= 1'b1;
      o_wrErr <= 1'b0;
      o_led   <= 1'b0;
    end else begin
      cs_q    <= i_cs;
      o_wrErr <= wr & ~wr_in;
      o_led   <= led_any;
    end
  end

  // Entry storage, written once per falling edge of the strobe
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        color_q[i] <= '0;
        mode_q[i]  <= '0;
      end
    end else if (wr && wr_in) begin
      color_q[i_ledNo] <= i_color;
      mode_q[i_ledNo]  <= i_mode;
    end
  end

  // Any entry not off lights the summary LED
  always_comb begin
    led_any = 1'b0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      led_any = led_any | (mode_q[i] != 2'b00);
    end
  end

  // Stage 1 combinational: tile coordinates, index, border and visibility
  logic [HW-1:0]  col_c;
  logic [VW-1:0]  row_c;
  logic [TSH-1:0] ox_c, oy_c;
  logic [31:0]    idx_c;
  logic           vis_c, grid_c, border_c, hs_c, vs_c;

  always_comb begin
    col_c    = hcnt_q >> TSH;
    row_c    = vcnt_q >> TSH;
    ox_c     = hcnt_q[TSH-1:0];
    oy_c     = vcnt_q[TSH-1:0];
    idx_c    = 32'(row_c) * COLS + 32'(col_c);
    vis_c    = (32'(hcnt_q) < H_VIS) && (32'(vcnt_q) < V_VIS);
    grid_c   = (32'(col_c) < COLS) && (idx_c < NUM_LEDS);
    border_c = (32'(ox_c) < BORDER_PX) || (32'(ox_c) >= TILE_PX - BORDER_PX) ||
               (32'(oy_c) < BORDER_PX) || (32'(oy_c) >= TILE_PX - BORDER_PX);
    hs_c     = !((32'(hcnt_q) >= H_VIS + H_FP) && (32'(hcnt_q) < H_VIS + H_FP + H_SYNC));
    vs_c     = !((32'(vcnt_q) >= V_VIS + V_FP) && (32'(vcnt_q) < V_VIS + V_FP + V_SYNC));
  end

  logic             vis_q, grid_q, border_q, hs1_q, vs1_q;
  logic [LED_W-1:0] idx_q;

  // Stage 1 registers
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      vis_q    <= 1'b0;
      grid_q   <= 1'b0;
      border_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      idx_q    <= '0;
    end else begin
      vis_q    <= vis_c;
      grid_q   <= grid_c;
      border_q <= border_c;
      hs1_q    <= hs_c;
      vs1_q    <= vs_c;
      idx_q    <= idx_c[LED_W-1:0];
    end
  end

  // Stage 2 combinational: entry read, lit decision and colour priority
  logic [3:0]  ent_color;
  logic [1:0]  ent_mode;
  logic        lit;
  logic [11:0] pix_c;

  always_comb begin
    ent_color = '0;
    ent_mode  = '0;
    // idx_q is only meaningful inside the grid
    if (grid_q) begin
      ent_color = color_q[idx_q];
      ent_mode  = mode_q[idx_q];
    end
    case (ent_mode)
      2'b01:   lit = 1'b1;
      2'b10:   lit = phase_q;
      2'b11:   lit = ~phase_q;
      default: lit = 1'b0;
    endcase
    if (!vis_q)        pix_c = 12'h000;
    else if (!grid_q)  pix_c = 12'h333;
    else if (border_q) pix_c = 12'h000;
    else if (lit)      pix_c = palette(ent_color);
    else               pix_c = 12'h111;
  end

  // Stage 2 registers: sync and colour leave together
  always_ff @(posedge i_clkVideo or negedge i_reset) begin
    if (!i_reset) begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
    end else begin
      o_hsync <= hs1_q;
      o_vsync <= vs1_q;
      o_red   <= pix_c[11:8];
      o_green <= pix_c[7:4];
      o_blue  <= pix_c[3:0];
    end
  end

endmodule

// File: tb/tb_visu_mon_grid.sv
// Randomised bench for visu_mon_grid: every output cycle is compared with a raster-position
// model of the grid, plus targeted strobe, error, reset, sync-timing and blink checks.
module tb_visu_mon_grid;

  localparam int unsigned NUM  = 12;
  localparam int unsigned LW   = 4;
  localparam int unsigned COLS = 8;
  localparam int unsigned TILE = 16;
  localparam int unsigned BRD  = 2;
  localparam int unsigned BF   = 2;
  localparam int unsigned HV = 136, HF = 4, HS = 12, HB = 4;
  localparam int unsigned VV = 34,  VF = 1, VS = 2,  VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cs = 1'b1;
  logic [LW-1:0] led_no = '0;
  logic [3:0]    color = '0;
  logic [1:0]    mode = '0;
  logic          hsync, vsync, led, wr_err;
  logic [3:0]    red, green, blue;

  visu_mon_grid #(
    .NUM_LEDS(NUM), .LED_W(LW), .COLS(COLS), .TILE_PX(TILE), .BORDER_PX(BRD),
    .BLINK_FRAMES(BF), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clkVideo(clk), .i_reset(rst_n), .i_cs(cs), .i_ledNo(led_no), .i_color(color),
    .i_mode(mode), .o_hsync(hsync), .o_vsync(vsync), .o_red(red), .o_green(green),
    .o_blue(blue), .o_led(led), .o_wrErr(wr_err)
  );

  always #5 clk = ~clk;

  logic [11:0] pal [16] = '{12'h000, 12'hFFF, 12'h800, 12'hAFE, 12'hC4C, 12'h0C5, 12'h00A,
                            12'hEE7, 12'hD85, 12'h640, 12'hF77, 12'h333, 12'h777, 12'hAF6,
                            12'h08F, 12'hBBB};

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [3:0] m_col  [NUM];
  logic [1:0] m_mode [NUM];
  int unsigned edges;
  logic        prev_cs;
  bit          hs_seen, vs_prev, blink_on, lit0, lit0_v, saw_on, saw_off;
  int          last_fall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  // Expected {hsync, vsync, rgb} for raster position p counted from reset release
  function automatic logic [13:0] exp_pix(input int unsigned p);
    int unsigned x, y, col, row, idx, ox, oy, ph;
    logic hs, vs, lt;
    logic [11:0] rgb;
    x   = p % HT;
    y   = (p / HT) % VT;
    hs  = !(x >= HV + HF && x < HV + HF + HS);
    vs  = !(y >= VV + VF && y < VV + VF + VS);
    // a frame start is counted at the very first clock, so frame k has seen k+1 starts
    ph  = (((p / FT) + 1) / BF) % 2;
    col = x / TILE;
    row = y / TILE;
    idx = row * COLS + col;
    ox  = x % TILE;
    oy  = y % TILE;
    if (x >= HV || y >= VV) rgb = 12'h000;
    else if (col >= COLS || idx >= NUM) rgb = 12'h333;
    else if (ox < BRD || ox >= TILE - BRD || oy < BRD || oy >= TILE - BRD) rgb = 12'h000;
    else begin
      case (m_mode[idx])
        2'd1:    lt = 1'b1;
        2'd2:    lt = (ph == 1);
        2'd3:    lt = (ph == 0);
        default: lt = 1'b0;
      endcase
      rgb = lt ? pal[m_col[idx]] : 12'h111;
    end
    return {hs, vs, rgb};
  endfunction

  task automatic tick();
    logic wr, led_e;
    logic [11:0] rgb;
    int unsigned p, x, y;
    @(negedge clk);
    rgb = {red, green, blue};
    if (!rst_n) begin
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_wrerr", 32'(wr_err), 32'd0);
      return;
    end
    edges++;
    if (!hs_seen && hsync == 1'b0) begin
      check("hs_first", edges, HV + HF + 2);
      hs_seen = 1'b1;
    end
    if (vs_prev && !vsync) begin
      if (last_fall >= 0) check("vs_period", edges - 32'(last_fall), FT);
      last_fall = int'(edges);
    end else if (!vs_prev && vsync && last_fall >= 0) begin
      check("vs_low", edges - 32'(last_fall), VS * HT);
    end
    vs_prev = vsync;
    if (edges >= 2) begin
      p = edges - 2;
      check("pix", 32'({hsync, vsync, rgb}), 32'(exp_pix(p)));
      x = p % HT;
      y = (p / HT) % VT;
      if (y == TILE / 2 && x == TILE / 2) begin
        lit0   = (rgb != 12'h111);
        lit0_v = 1'b1;
      end
      if (blink_on && lit0_v && y == TILE / 2 && x == 2 * TILE + TILE / 2) begin
        check("blink_excl", 32'(lit0 ^ (rgb != 12'h111)), 32'd1);
        if (lit0) saw_on = 1'b1;
        else saw_off = 1'b1;
        lit0_v = 1'b0;
      end
    end
    led_e = 1'b0;
    for (int i = 0; i < int'(NUM); i++) led_e = led_e | (m_mode[i] != 2'd0);
    check("led", 32'(led), 32'(led_e));
    wr = prev_cs && !cs;
    check("wrerr", 32'(wr_err), 32'(wr && led_no >= LW'(NUM)));
    if (wr && 32'(led_no) < NUM) begin
      m_col[led_no]  = color;
      m_mode[led_no] = mode;
    end
    prev_cs = cs;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    for (int i = 0; i < int'(NUM); i++) begin
      m_col[i]  = '0;
      m_mode[i] = '0;
    end
    repeat (n) tick();
    rst_n     = 1'b1;
    edges     = 0;
    prev_cs   = 1'b1;
    hs_seen   = 1'b0;
    vs_prev   = 1'b1;
    last_fall = -1;
    lit0_v    = 1'b0;
  endtask

  task automatic wr_entry(input int unsigned idx, input int unsigned c, input int unsigned m,
                          input int unsigned hold);
    led_no = LW'(idx);
    color  = 4'(c);
    mode   = 2'(m);
    cs     = 1'b0;
    repeat (hold) tick();
    cs = 1'b1;
    tick();
  endtask

  initial begin
    blink_on = 1'b0;
    saw_on   = 1'b0;
    saw_off  = 1'b0;
    #1;
    do_reset(3);
    // reset again in the middle of a line
    repeat (HT * 2 + 37) tick();
    do_reset(3);
    repeat (20) tick();
    // single-cycle strobe: entry 1 magenta, on
    wr_entry(1, 4, 1, 1);
    repeat (FT) tick();
    // long strobe: colour changes while held must not be written
    led_no = LW'(1);
    color  = 4'd4;
    mode   = 2'd1;
    cs     = 1'b0;
    tick();
    color = 4'd5;
    repeat (49) tick();
    cs = 1'b1;
    tick();
    repeat (FT / 2) tick();
    // out-of-range indices
    wr_entry(NUM, 7, 1, 1);
    repeat (3) tick();
    wr_entry(15, 2, 2, 2);
    repeat (3) tick();
    // random traffic
    for (int i = 0; i < 24; i++) begin
      wr_entry($urandom_range(15), $urandom_range(15), $urandom_range(3), $urandom_range(4, 1));
      repeat ($urandom_range(3)) tick();
    end
    repeat (FT) tick();
    // opposite-phase blink on tiles 0 and 2
    wr_entry(0, 2, 2, 1);
    wr_entry(2, 5, 3, 1);
    lit0_v   = 1'b0;
    blink_on = 1'b1;
    repeat (2 * BF * FT + HT) tick();
    check("blink_both_phases", 32'({saw_on, saw_off}), 32'd3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
